// File: rtl/xdn_pkg.sv
// rtl/xdn_pkg.sv - shared fetch sequencer constants, state encoding and output decode
package xdn_pkg;

    localparam int   XDN_BUS_WIDTH = 32;
    localparam logic XDN_OE_OFF    = 1'b1;

    typedef logic [2:0] xdn_state_t;

    localparam xdn_state_t S_CLEAR   = 3'd0;
    localparam xdn_state_t S_ADDR    = 3'd1;
    localparam xdn_state_t S_READ    = 3'd2;
    localparam xdn_state_t S_LOAD_IR = 3'd3;
    localparam xdn_state_t S_EXEC    = 3'd4;
    localparam xdn_state_t S_JUMP    = 3'd5;
    localparam xdn_state_t S_HALT    = 3'd6;
    localparam xdn_state_t S_FAULT   = 3'd7;

    typedef struct packed {
        logic pc_clear_n;
        logic pc_count_enable;
        logic pc_jump_n;
        logic pc_output_n;
        logic mar_load;
        logic mem_read;
        logic mem_output_n;
        logic ir_load;
        logic exec_start;
        logic target_output_n;
        logic halted;
        logic fault;
    } xdn_ctrl_t;

    // Control word for a state; exec_first marks the first cycle spent in EXEC.
    function automatic xdn_ctrl_t xdn_decode(xdn_state_t st, logic exec_first);
        xdn_ctrl_t c;
        c.pc_clear_n      = XDN_OE_OFF;
        c.pc_count_enable = 1'b0;
        c.pc_jump_n       = XDN_OE_OFF;
        c.pc_output_n     = XDN_OE_OFF;
        c.mar_load        = 1'b0;
        c.mem_read        = 1'b0;
        c.mem_output_n    = XDN_OE_OFF;
        c.ir_load         = 1'b0;
        c.exec_start      = 1'b0;
        c.target_output_n = XDN_OE_OFF;
        c.halted          = 1'b0;
        c.fault           = 1'b0;
        case (st)
            S_CLEAR:   c.pc_clear_n = 1'b0;
            S_ADDR: begin
                c.pc_output_n = 1'b0;
                c.mar_load    = 1'b1;
            end
            S_READ:    c.mem_read = 1'b1;
            S_LOAD_IR: begin
                c.mem_output_n    = 1'b0;
                c.ir_load         = 1'b1;
                c.pc_count_enable = 1'b1;
            end
            S_EXEC:    c.exec_start = exec_first;
            S_JUMP: begin
                c.target_output_n = 1'b0;
                c.pc_jump_n       = 1'b0;
            end
            S_HALT:    c.halted = 1'b1;
`ifdef XDN_FETCH_TIMEOUT_EN
            S_FAULT:   c.fault = 1'b1;
`endif
            default:   c.halted = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - handshake and bus-control bundle between sequencer and datapath
interface fetch_sequencer_if;
    import xdn_pkg::*;

    logic                     i_MEM_READY;
    logic                     i_EXEC_DONE;
    logic                     i_BRANCH_TAKEN;
    logic                     i_HALT_REQ;
    logic                     i_RESUME;
    logic                     o_PC_CLEAR_n;
    logic                     o_PC_COUNT_ENABLE;
    logic                     o_PC_JUMP_n;
    logic                     o_PC_OUTPUT_n;
    logic                     o_MAR_LOAD;
    logic                     o_MEM_READ;
    logic                     o_MEM_OUTPUT_n;
    logic                     o_IR_LOAD;
    logic                     o_EXEC_START;
    logic                     o_TARGET_OUTPUT_n;
    logic                     o_HALTED;
    logic                     o_FAULT;
    logic [XDN_BUS_WIDTH-1:0] o_RETIRED;

    modport master (
        input  i_MEM_READY, i_EXEC_DONE, i_BRANCH_TAKEN, i_HALT_REQ, i_RESUME,
        output o_PC_CLEAR_n, o_PC_COUNT_ENABLE, o_PC_JUMP_n, o_PC_OUTPUT_n,
               o_MAR_LOAD, o_MEM_READ, o_MEM_OUTPUT_n, o_IR_LOAD, o_EXEC_START,
               o_TARGET_OUTPUT_n, o_HALTED, o_FAULT, o_RETIRED
    );

    modport slave (
        output i_MEM_READY, i_EXEC_DONE, i_BRANCH_TAKEN, i_HALT_REQ, i_RESUME,
        input  o_PC_CLEAR_n, o_PC_COUNT_ENABLE, o_PC_JUMP_n, o_PC_OUTPUT_n,
               o_MAR_LOAD, o_MEM_READ, o_MEM_OUTPUT_n, o_IR_LOAD, o_EXEC_START,
               o_TARGET_OUTPUT_n, o_HALTED, o_FAULT, o_RETIRED
    );
endinterface

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - 8-bit saturating memory wait-state counter (used under XDN_FETCH_TIMEOUT_EN)
module wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic o_EXPIRED
);
    localparam logic [8:0] LIMIT_W = 9'(LIMIT);

    logic [7:0] count_q;
    logic [7:0] count_d;
    logic [8:0] count_inc;

    // Clear dominates; otherwise count enabled cycles and stick at full scale.
    always_comb begin
        count_inc = {1'b0, count_q} + 9'd1;
        count_d   = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (en && count_q != 8'hFF) begin
            count_d = count_inc[7:0];
        end
    end

    // Expiry flags the cycle whose increment reaches the limit, so the caller can act on the same edge.
    assign o_EXPIRED = en && !clr && (count_inc >= LIMIT_W);

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/execute/jump sequencer and bus-enable generator; XDN_FETCH_TIMEOUT_EN adds READ timeout
module fetch_sequencer
    import xdn_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               i_CLOCK,
    input  logic               i_RESET,
    fetch_sequencer_if.master  bus
);
    xdn_state_t               state_q, state_d;
    logic                     clear_hold_q, clear_hold_d;
    logic                     halt_pend_q, halt_pend_d;
    logic [XDN_BUS_WIDTH-1:0] retired_q, retired_d;
    xdn_ctrl_t                ctrl_q, ctrl_d;
    logic                     wait_expired;
    logic                     halt_now;
    logic                     leave_exec;

`ifdef XDN_FETCH_TIMEOUT_EN
    logic wait_clr;
    logic wait_en;

    assign wait_clr = (state_q != S_READ);
    assign wait_en  = (state_q == S_READ) && !bus.i_MEM_READY;

    wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
        .clk       (i_CLOCK),
        .rst       (i_RESET),
        .clr       (wait_clr),
        .en        (wait_en),
        .o_EXPIRED (wait_expired)
    );
`else
    assign wait_expired = 1'b0;
`endif

    // Next-state selection; a halt request only takes effect at an instruction boundary.
    always_comb begin
        state_d      = state_q;
        clear_hold_d = 1'b0;
        halt_now     = halt_pend_q | bus.i_HALT_REQ;
        case (state_q)
            S_CLEAR:   state_d = clear_hold_q ? S_CLEAR : S_ADDR;
            S_ADDR:    state_d = S_READ;
            S_READ: begin
                if (bus.i_MEM_READY) begin
                    state_d = S_LOAD_IR;
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_LOAD_IR: state_d = S_EXEC;
            S_EXEC: begin
                if (bus.i_EXEC_DONE) begin
                    if (bus.i_BRANCH_TAKEN) begin
                        state_d = S_JUMP;
                    end else begin
                        state_d = halt_now ? S_HALT : S_ADDR;
                    end
                end
            end
            S_JUMP:    state_d = halt_now ? S_HALT : S_ADDR;
            S_HALT:    state_d = bus.i_RESUME ? S_ADDR : S_HALT;
`ifdef XDN_FETCH_TIMEOUT_EN
            S_FAULT:   state_d = S_FAULT;
`endif
            default:   state_d = S_CLEAR;
        endcase
    end

    // Halt bookkeeping, retire count and the control word decoded from the next state.
    always_comb begin
        halt_pend_d = halt_now;
        if (state_d == S_HALT && state_q != S_HALT) begin
            halt_pend_d = 1'b0;
        end
        leave_exec = (state_q == S_EXEC) && (state_d != S_EXEC);
        retired_d  = retired_q + {{(XDN_BUS_WIDTH-1){1'b0}}, leave_exec};
        ctrl_d     = xdn_decode(state_d, state_q != S_EXEC);
    end

    // State and registered outputs; reset parks in CLEAR for one extra cycle after release.
    always_ff @(posedge i_CLOCK) begin
        if (i_RESET) begin
            state_q      <= S_CLEAR;
            clear_hold_q <= 1'b1;
            halt_pend_q  <= 1'b0;
            retired_q    <= '0;
            ctrl_q       <= xdn_decode(S_CLEAR, 1'b0);
        end else begin
            state_q      <= state_d;
            clear_hold_q <= clear_hold_d;
            halt_pend_q  <= halt_pend_d;
            retired_q    <= retired_d;
            ctrl_q       <= ctrl_d;
        end
    end

    assign bus.o_PC_CLEAR_n      = ctrl_q.pc_clear_n;
    assign bus.o_PC_COUNT_ENABLE = ctrl_q.pc_count_enable;
    assign bus.o_PC_JUMP_n       = ctrl_q.pc_jump_n;
    assign bus.o_PC_OUTPUT_n     = ctrl_q.pc_output_n;
    assign bus.o_MAR_LOAD        = ctrl_q.mar_load;
    assign bus.o_MEM_READ        = ctrl_q.mem_read;
    assign bus.o_MEM_OUTPUT_n    = ctrl_q.mem_output_n;
    assign bus.o_IR_LOAD         = ctrl_q.ir_load;
    assign bus.o_EXEC_START      = ctrl_q.exec_start;
    assign bus.o_TARGET_OUTPUT_n = ctrl_q.target_output_n;
    assign bus.o_HALTED          = ctrl_q.halted;
    assign bus.o_FAULT           = ctrl_q.fault;
    assign bus.o_RETIRED         = retired_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard testbench for fetch_sequencer
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_sequencer_if bus();

    fetch_sequencer #(.MEM_TIMEOUT(4)) dut (
        .i_CLOCK (clk),
        .i_RESET (rst),
        .bus     (bus)
    );

    typedef struct {
        int          cycles;
        logic [31:0] retired;
        bit          branch;
        bit          halt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_retired;
    bit          halt_carry = 0;
    bit          mon_en = 0;
    bit          in_instr = 0;
    int          cyc, jumps, starts, counts, loads;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic finish_bench();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // Bus ownership rule, every cycle.
    always @(negedge clk) begin
        int lows;
        lows = int'(!bus.o_PC_OUTPUT_n) + int'(!bus.o_MEM_OUTPUT_n) + int'(!bus.o_TARGET_OUTPUT_n);
        assert (lows <= 1) else $error("bus contention");
        check("bus_rule", (lows <= 1) ? 32'd1 : 32'd0, 32'd1);
    end

    // Monitor: an instruction spans from its ADDR cycle to the next ADDR or HALT cycle.
    always @(negedge clk) begin
        if (!mon_en) begin
            in_instr = 0;
        end else begin
            if (in_instr && (bus.o_PC_OUTPUT_n == 1'b0 || bus.o_HALTED)) begin
                in_instr = 0;
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("instr_cycles", cyc, mon_e.cycles);
                    check("retired", bus.o_RETIRED, mon_e.retired);
                    check("jump_cycles", jumps, {31'd0, mon_e.branch});
                    check("halted_after", {31'd0, bus.o_HALTED}, {31'd0, mon_e.halt});
                    check("exec_start_pulses", starts, 1);
                    check("pc_count_pulses", counts, 1);
                    check("ir_load_pulses", loads, 1);
                end
            end
            if (bus.o_PC_OUTPUT_n == 1'b0) begin
                in_instr = 1;
                cyc = 0; jumps = 0; starts = 0; counts = 0; loads = 0;
            end
            if (in_instr) begin
                cyc++;
                if (!bus.o_PC_JUMP_n && !bus.o_TARGET_OUTPUT_n) jumps++;
                if (bus.o_EXEC_START) starts++;
                if (bus.o_PC_COUNT_ENABLE) counts++;
                if (bus.o_IR_LOAD) loads++;
            end
        end
    end

    // Called at the negedge of an ADDR cycle; plays memory and execute unit for one instruction.
    task automatic run_instr(int waits, int ecyc, bit br, int halt_at);
        exp_t e;
        model_retired = model_retired + 32'd1;
        e.cycles  = 4 + waits + (ecyc - 1) + int'(br);
        e.retired = model_retired;
        e.branch  = br;
        e.halt    = halt_carry || (halt_at != 0);
        halt_carry = 0;
        exp_q.push_back(e);
        @(negedge clk);
        bus.i_HALT_REQ  = (halt_at == 1);
        bus.i_MEM_READY = (waits == 0);
        for (int w = 1; w <= waits; w++) begin
            @(negedge clk);
            bus.i_HALT_REQ  = 1'b0;
            bus.i_MEM_READY = (w == waits);
        end
        @(negedge clk);
        bus.i_HALT_REQ  = 1'b0;
        bus.i_MEM_READY = 1'b0;
        for (int c = 1; c <= ecyc; c++) begin
            @(negedge clk);
            bus.i_EXEC_DONE    = (c == ecyc);
            bus.i_BRANCH_TAKEN = br;
            bus.i_HALT_REQ     = (halt_at == 2) && (c == ecyc);
        end
        @(negedge clk);
        bus.i_EXEC_DONE    = 1'b0;
        bus.i_BRANCH_TAKEN = 1'b0;
        bus.i_HALT_REQ     = 1'b0;
    endtask

    // Advance to the next ADDR cycle, resuming one cycle after HALT is seen.
    task automatic wait_addr();
        int hc;
        bit resumed;
        hc = 0;
        resumed = 0;
        for (int i = 0; i < 40; i++) begin
            if (resumed) begin
                check("resume_to_addr", {31'd0, bus.o_PC_OUTPUT_n}, 32'd0);
                resumed = 0;
                bus.i_RESUME   = 1'b0;
                bus.i_HALT_REQ = 1'b0;
            end
            if (bus.o_PC_OUTPUT_n == 1'b0) return;
            if (bus.o_HALTED) begin
                hc++;
                if (hc == 2) begin
                    halt_carry     = ($urandom_range(0, 3) == 0);
                    bus.i_RESUME   = 1'b1;
                    bus.i_HALT_REQ = halt_carry;
                    resumed        = 1;
                end
            end
            @(negedge clk);
        end
        n_fail++;
        $display("FAIL wait_addr: no ADDR cycle within 40 cycles");
        finish_bench();
    endtask

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_bench();
    end

    initial begin
        int waits, ecyc, halt_at, rd;
        bit br;
        bus.i_MEM_READY    = 1'b0;
        bus.i_EXEC_DONE    = 1'b0;
        bus.i_BRANCH_TAKEN = 1'b0;
        bus.i_HALT_REQ     = 1'b0;
        bus.i_RESUME       = 1'b0;
        model_retired      = 32'd0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_pc_clear_n", {31'd0, bus.o_PC_CLEAR_n}, 32'd0);
            check("rst_pc_output_n", {31'd0, bus.o_PC_OUTPUT_n}, 32'd1);
            check("rst_retired", bus.o_RETIRED, 32'd0);
        end
        rst = 1'b0;
        mon_en = 1;
        @(negedge clk);
        check("clear_hold", {31'd0, bus.o_PC_CLEAR_n}, 32'd0);
        check("clear_hold_mar", {31'd0, bus.o_MAR_LOAD}, 32'd0);
        @(negedge clk);
        check("first_addr_pc_out", {31'd0, bus.o_PC_OUTPUT_n}, 32'd0);
        check("first_addr_mar", {31'd0, bus.o_MAR_LOAD}, 32'd1);
        check("first_addr_clear_n", {31'd0, bus.o_PC_CLEAR_n}, 32'd1);

        for (int i = 0; i < 3; i++) begin
            run_instr(0, 1, 0, 0);
            wait_addr();
        end
        check("straight_line_retired", bus.o_RETIRED, 32'd3);

        run_instr(0, 1, 1, 0);
        wait_addr();
        run_instr(1, 2, 0, 1);
        wait_addr();
        run_instr(0, 1, 1, 2);
        wait_addr();

        #1;
        force dut.retired_q = 32'hFFFF_FFFF;
        model_retired = 32'hFFFF_FFFF;
        fork
            begin
                @(negedge clk);
                release dut.retired_q;
            end
        join_none
        run_instr(0, 1, 0, 0);
        wait_addr();
        check("retired_wrap", bus.o_RETIRED, 32'd0);

        for (int n = 0; n < 40; n++) begin
            waits   = int'($urandom_range(0, 3));
            ecyc    = int'($urandom_range(1, 3));
            br      = ($urandom_range(0, 3) == 0);
            rd      = int'($urandom_range(0, 9));
            halt_at = (rd == 0) ? 1 : ((rd == 1) ? 2 : 0);
            run_instr(waits, ecyc, br, halt_at);
            wait_addr();
        end
`ifndef XDN_FETCH_TIMEOUT_EN
        run_instr(20, 1, 0, 0);
        wait_addr();
`endif
        mon_en = 0;
        exp_q.delete();

        @(negedge clk);
        bus.i_MEM_READY = 1'b1;
        @(negedge clk);
        bus.i_MEM_READY = 1'b0;
        @(negedge clk);
        check("exec_start_before_reset", {31'd0, bus.o_EXEC_START}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_exec_rst_clear_n", {31'd0, bus.o_PC_CLEAR_n}, 32'd0);
        check("mid_exec_rst_oe", {29'd0, bus.o_PC_OUTPUT_n, bus.o_MEM_OUTPUT_n, bus.o_TARGET_OUTPUT_n}, 32'd7);
        check("mid_exec_rst_jump_n", {31'd0, bus.o_PC_JUMP_n}, 32'd1);
        check("mid_exec_rst_retired", bus.o_RETIRED, 32'd0);
        check("mid_exec_rst_fault", {31'd0, bus.o_FAULT}, 32'd0);
        rst = 1'b0;

`ifdef XDN_FETCH_TIMEOUT_EN
        begin
            int reads;
            reads = 0;
            @(negedge clk);
            @(negedge clk);
            check("fault_pre_addr", {31'd0, bus.o_PC_OUTPUT_n}, 32'd0);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.o_MEM_READ) reads++;
                if (bus.o_FAULT) break;
            end
            check("fault_read_cycles", reads, 4);
            check("fault_flag", {31'd0, bus.o_FAULT}, 32'd1);
            repeat (3) @(negedge clk);
            check("fault_sticky", {31'd0, bus.o_FAULT}, 32'd1);
            check("fault_no_read", {31'd0, bus.o_MEM_READ}, 32'd0);
            rst = 1'b1;
            @(negedge clk);
            check("fault_reset_clears", {31'd0, bus.o_FAULT}, 32'd0);
            check("fault_reset_clear_n", {31'd0, bus.o_PC_CLEAR_n}, 32'd0);
            rst = 1'b0;
        end
`endif
        repeat (2) @(negedge clk);
        finish_bench();
    end
endmodule
